// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 floor-call keypad scanner.
// Holds the FSM state enum, matrix geometry, idle/reset pin patterns and the
// row-priority encoder used to build a key code from a sampled row vector.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // All rows released (pull-ups win) and the column-0 strobe pattern
    localparam logic [ROWS-1:0] ROW_IDLE  = 4'b1111;
    localparam logic [COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // Index of the lowest-numbered row that is pulled low; 0 if none are low
    function automatic logic [1:0] row_encode(input logic [ROWS-1:0] rows);
        row_encode = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) row_encode = 2'(i);
        end
    endfunction

    // Active-low one-hot strobe for a column index
    function automatic logic [COLS-1:0] col_strobe(input logic [1:0] idx);
        col_strobe = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running prescaler producing a one-clk scan tick every
// SCAN_DIV cycles (tick is high while the prescaler sits at SCAN_DIV-1).
module keypad_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler;

    assign tick = (prescaler == PW'(SCAN_DIV - 1));

    // Count 0..SCAN_DIV-1 and wrap on the tick cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     prescaler <= '0;
        else if (tick) prescaler <= '0;
        else           prescaler <= prescaler + 1'b1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 keypad column by column (active-low), samples
// the active-low rows through a 2-flop synchronizer, debounces one key and
// reports it as key_code with a one-clk key_valid strobe and a held flag.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat strobes while held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = 4;

    logic [3:0]    row_s1, row_s2;
    logic          tick;
    state_t        state;
    logic [1:0]    col_idx;
    logic [1:0]    col_next;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic          any_low;
    logic [3:0]    samp_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rpt;
`endif

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign any_low   = ~&row_s2;
    assign samp_code = {row_encode(row_s2), col_idx};
    assign col_next  = col_idx + 2'd1;

    // Two-flop synchronizer for the asynchronous row pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1 <= ROW_IDLE;
            row_s2 <= ROW_IDLE;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // Scan / debounce / hold FSM; everything moves on ticks except the valid clear.
    // In DEBOUNCE, cnt counts matching samples including the detecting one, so
    // acceptance lands DEBOUNCE_SCANS ticks after detection. In PRESSED, cnt
    // counts consecutive all-high ticks toward release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= COL_RESET;
            cand      <= 4'd0;
            cnt       <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (!any_low) begin
                            col_idx <= col_next;
                            col_out <= col_strobe(col_next);
                        end else begin
                            cand  <= samp_code;
                            cnt   <= CW'(1);
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (any_low && samp_code == cand) begin
                            if (cnt == CW'(DEBOUNCE_SCANS)) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rpt       <= '0;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_next;
                            col_out <= col_strobe(col_next);
                        end
                    end
                    PRESSED: begin
                        if (!any_low) begin
`ifdef KEYPAD_REPEAT_EN
                            rpt <= '0;
`endif
                            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                                key_held <= 1'b0;
                                cnt      <= '0;
                                state    <= SCAN;
                                col_idx  <= col_next;
                                col_out  <= col_strobe(col_next);
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rpt == RW'(REPEAT_SCANS - 1)) begin
                                rpt       <= '0;
                                key_valid <= 1'b1;
                            end else begin
                                rpt <= rpt + 1'b1;
                            end
`endif
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a tick-level behavioural
// model checked against the DUT every cycle, plus literal expectations.
module tb_keypad_scanner;

    localparam int SD = 8;
    localparam int DB = 4;
    localparam int RP = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;

    int vectors = 0;
    int errs    = 0;
    int pulses  = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_SCANS(RP)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model, tick granularity: which column is being looked at,
    // which key is a candidate, how many agreeing ticks followed detection,
    // how many release ticks in a row, ticks since the last repeat strobe.
    int         m_pc, m_col, m_cand, m_after, m_rel, m_since, m_code, hit;
    bit         m_valid, m_held;
    logic [3:0] m_s1, m_s2, m_v;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0; m_col = 0; m_cand = -1; m_after = 0; m_rel = 0; m_since = 0;
            m_code = 0; m_valid = 0; m_held = 0; m_s1 = 4'hf; m_s2 = 4'hf;
        end else begin
            m_v = m_s2; m_s2 = m_s1; m_s1 = row_in;
            m_valid = 0;
            if (m_pc == SD - 1) begin
                hit = -1;
                for (int r = 3; r >= 0; r--) if (!m_v[r]) hit = r * 4 + m_col;
                if (m_held) begin
                    if (hit < 0) begin
                        m_rel++; m_since = 0;
                        if (m_rel == DB) begin m_held = 0; m_col = (m_col + 1) % 4; end
                    end else begin
                        m_rel = 0;
`ifdef KEYPAD_REPEAT_EN
                        m_since++;
                        if (m_since == RP) begin m_since = 0; m_valid = 1; end
`endif
                    end
                end else if (m_cand < 0) begin
                    if (hit < 0) m_col = (m_col + 1) % 4;
                    else begin m_cand = hit; m_after = 0; end
                end else if (hit == m_cand) begin
                    m_after++;
                    if (m_after == DB) begin
                        m_held = 1; m_code = m_cand; m_valid = 1;
                        m_cand = -1; m_rel = 0; m_since = 0;
                    end
                end else begin
                    m_cand = -1; m_col = (m_col + 1) % 4;
                end
            end
            m_pc = (m_pc + 1) % SD;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [3:0] exp_col;
        if (!reset) begin
            exp_col = ~(4'b0001 << m_col);
            check("col_out", col_out, exp_col);
            check("key_code", key_code, m_code);
            check("key_valid", key_valid, m_valid);
            check("key_held", key_held, m_held);
            if (key_valid) pulses++;
        end
    end

    // Wait for a fresh strobe of column col, then press the keys in mask
    task automatic press_aligned(input int col, input logic [15:0] mask);
        logic [3:0] pat;
        int n;
        pat = ~(4'b0001 << col);
        n = 0;
        while (col_out == pat && n < 100) begin @(negedge clk); n++; end
        while (col_out != pat && n < 200) begin @(negedge clk); n++; end
        check("align_col", col_out, pat);
        pulses = 0;
        keys = mask;
    endtask

    initial begin
        reset = 1'b1;
        keys  = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_code", key_code, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        reset = 1'b0;

        // 1: steady key 6
        press_aligned(2, 16'h0040);
        repeat (48) @(negedge clk);
        check("t1_pulses", pulses, 1);
        check("t1_code", key_code, 4'd6);
        check("t1_held", key_held, 1'b1);
        keys = 16'h0;
        repeat (24) @(negedge clk);
        check("t1_held_3rel", key_held, 1'b1);
        repeat (9) @(negedge clk);
        check("t1_held_4rel", key_held, 1'b0);
        check("t1_pulses_end", pulses, 1);

        // 2: key 6 for two ticks then bounce high
        press_aligned(2, 16'h0040);
        repeat (16) @(negedge clk);
        keys = 16'h0;
        repeat (12) @(negedge clk);
        check("t2_pulses", pulses, 0);
        check("t2_held", key_held, 1'b0);
        check("t2_col_resume", col_out, 4'b0111);

        // 3: rows 1 and 3 on column 0 -> row 1 wins
        press_aligned(0, 16'h1010);
        repeat (48) @(negedge clk);
        check("t3_pulses", pulses, 1);
        check("t3_code", key_code, 4'd4);
        keys = 16'h0;
        repeat (40) @(negedge clk);

        // 4: reset in the middle of debounce
        press_aligned(2, 16'h0040);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_col", col_out, 4'b1110);
        check("t4_rst_held", key_held, 1'b0);
        check("t4_rst_valid", key_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) @(negedge clk);
        check("t4_no_early", pulses, 0);
        repeat (20) @(negedge clk);
        check("t4_pulses", pulses, 1);
        check("t4_code", key_code, 4'd6);
        keys = 16'h0;
        repeat (40) @(negedge clk);

        // 5: release glitch while held
        press_aligned(2, 16'h0040);
        repeat (40) @(negedge clk);
        keys = 16'h0;
        repeat (16) @(negedge clk);
        keys = 16'h0040;
        repeat (32) @(negedge clk);
        check("t5_held", key_held, 1'b1);
        check("t5_pulses", pulses, 1);
        keys = 16'h0;
        repeat (40) @(negedge clk);
        check("t5_released", key_held, 1'b0);

`ifdef KEYPAD_REPEAT_EN
        // 6: auto-repeat on key 15
        press_aligned(3, 16'h8000);
        repeat (200) @(negedge clk);
        check("t6_pulses", pulses, 4);
        check("t6_code", key_code, 4'd15);
        keys = 16'h0;
        repeat (40) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
